ws_rx_apb: RTL and testbench

WS_RX_APB -- requirements
Module: ws_rx_apb

---
 rtl/ws_rx_apb_pkg.sv | 30 +++
 rtl/ws_pulse_meter.sv | 111 +++++++++++
 rtl/ws_rx_apb.sv | 159 +++++++++++++++
 tb/tb_ws_rx_apb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ws_rx_apb_pkg.sv
// Shared definitions for the LED-strip receiver: FSM encoding, register offsets, STATUS/CTRL layout.
// Used by the receiver RTL and by transmitter-side drivers/benches.
package ws_rx_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } ws_state_t;

  localparam logic [3:0] REG_STATUS = 4'd8;
  localparam logic [3:0] REG_CTRL   = 4'd9;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int BITS_PER_WORD = 24;

  // Field order fixes the STATUS bit positions: frame_done is bit 0, word_cnt is [15:12].
  typedef struct packed {
    logic [3:0] word_cnt;
    logic [7:0] bit_cnt;
    logic       busy;
    logic       pulse_err;
    logic       overflow;
    logic       frame_done;
  } status_t;

endpackage

// File: rtl/ws_pulse_meter.sv
// Synchronizes DIN and times high/low phases, emitting one-cycle start/bit/error/frame-end strobes.
// Latency: 2 sync flops + 1 edge-detect cycle; no backpressure, strobes are valid only in the cycle they fire.
module ws_pulse_meter
  import ws_rx_apb_pkg::*;
#(
  parameter int HIGH_THRESH = 60,
  parameter int MIN_HIGH    = 20,
  parameter int MAX_HIGH    = 100,
  parameter int RESET_CYC   = 6000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic en,
  output logic busy,
  output logic start,
  output logic bit_vld,
  output logic bit_dat,
  output logic pulse_err,
  output logic frame_end
);

  localparam int CNT_TOP = (RESET_CYC > MAX_HIGH + 1) ? RESET_CYC : MAX_HIGH + 1;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] THRESH  = CW'(HIGH_THRESH);
  localparam logic [CW-1:0] MIN_C   = CW'(MIN_HIGH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_HIGH);
  localparam logic [CW-1:0] LOW_END = CW'(RESET_CYC - 1);

  logic          sync1, din_s, din_d, armed;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;
  logic          rise, fall, short_hi, long_hi;
  ws_state_t     state, state_nxt;

  // armed blocks the reset-release edge: a rise only counts after a valid low has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= din;
      din_s <= sync1;
      din_d <= din_s;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && !din_s) armed <= 1'b1;
    end
  end

  assign rise     = armed & din_s & ~din_d;
  assign fall     = din_d & ~din_s;
  assign short_hi = (cnt < MIN_C);
  assign long_hi  = (cnt > MAX_C);

  // Loading 1 counts the edge cycle itself, so cnt equals the phase length in cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt <= '0;
    else if (rise || (state == ST_HIGH && fall)) cnt <= CW'(1);
    else if (cnt != CNT_MAX)               cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (rise) state_nxt = ST_HIGH;
        ST_HIGH: if (fall) state_nxt = long_hi ? ST_IDLE : ST_LOW;
        ST_LOW: begin
          if (rise)                state_nxt = ST_HIGH;
          else if (cnt >= LOW_END) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    start     = 1'b0;
    bit_vld   = 1'b0;
    bit_dat   = 1'b0;
    pulse_err = 1'b0;
    frame_end = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: start = rise;
        ST_HIGH: begin
          if (fall) begin
            pulse_err = short_hi | long_hi;
            bit_vld   = ~(short_hi | long_hi);
            bit_dat   = (cnt >= THRESH);
          end
        end
        ST_LOW:  frame_end = ~rise & (cnt >= LOW_END);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ws_rx_apb.sv
// APB slave capturing LED-strip serial frames into a word buffer with status flags and a frame-done IRQ.
// Zero-wait-state APB (PREADY tied high); DIN decode trails the line by 3 cycles and never stalls.
module ws_rx_apb
  import ws_rx_apb_pkg::*;
#(
  parameter int NUM_WORDS   = 8,
  parameter int HIGH_THRESH = 60,
  parameter int MIN_HIGH    = 20,
  parameter int MAX_HIGH    = 100,
  parameter int RESET_CYC   = 6000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        DIN,
  output logic        IRQ
);

  localparam int WPW = $clog2(NUM_WORDS + 1);

  logic [3:0]                 addr;
  logic                       wr, clr;
  logic                       en, irq_en, irq;
  logic [NUM_WORDS-1:0][23:0] data;
  logic [WPW-1:0]             wptr;
  logic [4:0]                 bptr;
  logic                       fresh, frame_done, overflow, pulse_err;
  logic [7:0]                 bit_cnt;
  logic [3:0]                 word_cnt;
  logic                       m_busy, m_start, m_bit_vld, m_bit_dat, m_err, m_frame_end;
  status_t                    st;
  logic                       unused;

  assign addr    = PADDR[5:2];
  assign wr      = PSEL & PENABLE & PWRITE;
  assign clr     = wr && (addr == REG_CTRL) && PWDATA[CTRL_CLR];
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign IRQ     = irq;
  assign unused  = ^{PADDR[31:6], PADDR[1:0], PWDATA[31:3]};

  ws_pulse_meter #(
    .HIGH_THRESH (HIGH_THRESH),
    .MIN_HIGH    (MIN_HIGH),
    .MAX_HIGH    (MAX_HIGH),
    .RESET_CYC   (RESET_CYC)
  ) u_meter (
    .clk       (PCLK),
    .rst_n     (PRESERN),
    .din       (DIN),
    .en        (en),
    .busy      (m_busy),
    .start     (m_start),
    .bit_vld   (m_bit_vld),
    .bit_dat   (m_bit_dat),
    .pulse_err (m_err),
    .frame_end (m_frame_end)
  );

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr && addr == REG_CTRL) begin
      en     <= PWDATA[CTRL_EN];
      irq_en <= PWDATA[CTRL_IRQ_EN];
    end
  end

  // CLR is applied first so any event in the same cycle overrides it.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      data       <= '0;
      wptr       <= '0;
      bptr       <= '0;
      fresh      <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      pulse_err  <= 1'b0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      irq        <= 1'b0;
    end else begin
      irq <= frame_done & irq_en;
      if (clr) begin
        frame_done <= 1'b0;
        overflow   <= 1'b0;
        pulse_err  <= 1'b0;
        bit_cnt    <= '0;
        word_cnt   <= '0;
      end
      if (m_start) fresh <= 1'b1;
      if (m_err) pulse_err <= 1'b1;
      if (m_bit_vld) begin
        fresh <= 1'b0;
        if (fresh) begin
          data       <= '0;
          data[0][0] <= m_bit_dat;
          wptr       <= '0;
          bptr       <= 5'd1;
          bit_cnt    <= 8'd1;
          word_cnt   <= '0;
          frame_done <= 1'b0;
        end else begin
          if (bit_cnt != 8'hFF) bit_cnt <= bit_cnt + 1'b1;
          if (wptr == WPW'(NUM_WORDS)) begin
            overflow <= 1'b1;
          end else begin
            for (int i = 0; i < NUM_WORDS; i++)
              if (wptr == WPW'(i)) data[i][bptr] <= m_bit_dat;
            if (bptr == 5'(BITS_PER_WORD - 1)) begin
              bptr <= '0;
              wptr <= wptr + 1'b1;
            end else begin
              bptr <= bptr + 1'b1;
            end
          end
        end
      end
      // A still-fresh frame accepted no bits, so it must not raise FRAME_DONE.
      if (m_frame_end && !fresh && bit_cnt != 8'd0) begin
        frame_done <= 1'b1;
        word_cnt   <= 4'(wptr);
      end
    end
  end

  always_comb begin
    st            = '0;
    st.word_cnt   = word_cnt;
    st.bit_cnt    = bit_cnt;
    st.busy       = m_busy;
    st.pulse_err  = pulse_err;
    st.overflow   = overflow;
    st.frame_done = frame_done;
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (addr == REG_STATUS) begin
        PRDATA = {16'h0, st};
      end else if (addr == REG_CTRL) begin
        PRDATA = {30'h0, irq_en, en};
      end else begin
        for (int i = 0; i < NUM_WORDS; i++)
          if (addr == 4'(i)) PRDATA = {8'h0, data[i]};
      end
    end
  end

endmodule

// File: tb/tb_ws_rx_apb.sv
// Directed bench for ws_rx_apb: frame capture, overflow, pulse errors, CLR/IRQ timing and reset mid-pulse.
module tb_ws_rx_apb;
  import ws_rx_apb_pkg::*;

  localparam int R = 6000;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, DIN = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, IRQ;

  int checks = 0;
  int errors = 0;

  logic [23:0] pat;
  logic [23:0] exp_w;

  ws_rx_apb dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .DIN     (DIN),
    .IRQ     (IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Call just after a falling edge; PRDATA is combinational so the sample is taken 1 ns later.
  task automatic rd_check(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {26'h0, idx, 2'b00};
    #1;
    check(tag, PRDATA, exp);
    PSEL = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] idx, input logic [31:0] val);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {26'h0, idx, 2'b00}; PWDATA = val;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic send_pulse(input int hi);
    DIN = 1'b1;
    repeat (hi) @(negedge PCLK);
    DIN = 1'b0;
    repeat (125 - hi) @(negedge PCLK);
  endtask

  task automatic wait_frame();
    repeat (R + 20) @(negedge PCLK);
  endtask

  function automatic logic fbit(input int i);
    int t;
    t = (i * 13) >> 2;
    return t[0];
  endfunction

  initial begin
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
    repeat (3) @(negedge PCLK);

    check("pready", 32'(PREADY), 32'h1);
    check("pslverr", 32'(PSLVERR), 32'h0);
    check("irq_rst", 32'(IRQ), 32'h0);
    rd_check("status_rst", REG_STATUS, 32'h0);
    rd_check("ctrl_rst", REG_CTRL, 32'h0);
    rd_check("data0_rst", 4'd0, 32'h0);

    apb_write(REG_CTRL, 32'h1);
    rd_check("ctrl_en", REG_CTRL, 32'h1);
    apb_write(REG_STATUS, 32'hFFFF);
    rd_check("status_ro", REG_STATUS, 32'h0);
    rd_check("unmapped", 4'd12, 32'h0);

    // 24-bit frame, bit 0 first
    pat = 24'hA5C3F0;
    for (int i = 0; i < 24; i++) send_pulse(pat[i] ? 80 : 40);
    wait_frame();
    rd_check("f1_data0", 4'd0, 32'h00A5C3F0);
    rd_check("f1_status", REG_STATUS, 32'h0000_1181);
    check("f1_irq_off", 32'(IRQ), 32'h0);

    // EN dropped mid-frame keeps partial data and does not complete the frame
    send_pulse(80); send_pulse(40); send_pulse(80);
    rd_check("en_busy", REG_STATUS, 32'h0000_0038);
    apb_write(REG_CTRL, 32'h0);
    repeat (2) @(negedge PCLK);
    rd_check("en_off_status", REG_STATUS, 32'h0000_0030);
    rd_check("en_off_data0", 4'd0, 32'h0000_0005);

    // Overflow: 200 bits into a 192-bit buffer
    apb_write(REG_CTRL, 32'h5);
    rd_check("clr_status", REG_STATUS, 32'h0);
    for (int i = 0; i < 200; i++) send_pulse(fbit(i) ? 80 : 40);
    wait_frame();
    rd_check("ovf_status", REG_STATUS, 32'h0000_8C83);
    for (int j = 0; j < 24; j++) exp_w[j] = fbit(j);
    rd_check("ovf_data0", 4'd0, {8'h0, exp_w});
    for (int j = 0; j < 24; j++) exp_w[j] = fbit(168 + j);
    rd_check("ovf_data7", 4'd7, {8'h0, exp_w});

    // Short pulse in the middle is discarded and flagged
    apb_write(REG_CTRL, 32'h5);
    rd_check("clr2_status", REG_STATUS, 32'h0);
    pat = 24'h5A3C96;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) send_pulse(10);
      send_pulse(pat[i] ? 80 : 40);
    end
    wait_frame();
    rd_check("perr_status", REG_STATUS, 32'h0000_1185);
    rd_check("perr_data0", 4'd0, 32'h005A3C96);

    // CLR written in the frame-end cycle: FRAME_DONE set wins, IRQ follows one cycle later
    apb_write(REG_CTRL, 32'h7);
    rd_check("clr3_status", REG_STATUS, 32'h0);
    send_pulse(80); send_pulse(80); send_pulse(40);
    DIN = 1'b1;
    repeat (80) @(negedge PCLK);
    DIN = 1'b0;
    repeat (R) @(negedge PCLK);
    rd_check("pre_end_status", REG_STATUS, 32'h0000_0048);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {26'h0, REG_CTRL, 2'b00}; PWDATA = 32'h7;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check("irq_lag0", 32'(IRQ), 32'h0);
    rd_check("clr_race_status", REG_STATUS, 32'h0000_0001);
    @(negedge PCLK);
    check("irq_set", 32'(IRQ), 32'h1);
    rd_check("irq_data0", 4'd0, 32'h0000_000B);
    apb_write(REG_CTRL, 32'h7);
    rd_check("clr4_status", REG_STATUS, 32'h0);
    check("irq_hold", 32'(IRQ), 32'h1);
    @(negedge PCLK);
    check("irq_clear", 32'(IRQ), 32'h0);

    // Reset asserted mid-high and released while DIN is still high
    DIN = 1'b1;
    repeat (30) @(negedge PCLK);
    PRESERN = 1'b0;
    repeat (2) @(negedge PCLK);
    check("irq_in_rst", 32'(IRQ), 32'h0);
    PRESERN = 1'b1;
    repeat (5) @(negedge PCLK);
    rd_check("rst2_status", REG_STATUS, 32'h0);
    rd_check("rst2_ctrl", REG_CTRL, 32'h0);
    rd_check("rst2_data0", 4'd0, 32'h0);
    apb_write(REG_CTRL, 32'h1);
    repeat (20) @(negedge PCLK);
    DIN = 1'b0;
    repeat (50) @(negedge PCLK);
    rd_check("rst2_no_bit", REG_STATUS, 32'h0);
    send_pulse(80);
    rd_check("rst2_fresh_bit", REG_STATUS, 32'h0000_0018);
    rd_check("rst2_data0_bit", 4'd0, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
